// File: rtl/hor_line_feeder.sv
// Ping-pong line buffer: absorbs a free-running pixel stream and replays each
// committed line to the horizontal filter as an HSync pulse plus a ready-throttled burst.
module hor_line_feeder #(
  parameter int LINE_W    = 11,
  parameter int HSYNC_LEN = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [7:0]      vid_pData_i,
  input  logic            vid_pHSync_i,
  input  logic            vid_pVSync_i,
  input  logic            vid_pVDE_i,
  output logic [7:0]      vid_pData_o,
  output logic            vid_pHSync_o,
  output logic            vid_pVSync_o,
  output logic            vid_pVDE_o,
  input  logic            vid_pReady_i,
  input  logic            sw_reset,
  output logic            overflow_o,
  output logic [LINE_W:0] line_len_o
);
  localparam int DEPTH = 1 << LINE_W;
  localparam int HC_W  = (HSYNC_LEN > 1) ? $clog2(HSYNC_LEN) : 1;

  typedef enum logic [1:0] {R_IDLE, R_HSYNC, R_GAP, R_STREAM} rstate_t;

  logic [7:0] mem [0:2*DEPTH-1];
  logic [7:0] rd_data_reg;

  logic                 wbank_reg;
  logic                 rbank_reg;
  logic                 vde_d_reg;
  logic [LINE_W:0]      waddr_reg;
  logic [LINE_W-1:0]    raddr_reg;
  logic [1:0][LINE_W:0] len_reg;
  logic [1:0]           full_reg;
  rstate_t              rstate_reg;
  logic [HC_W-1:0]      hcnt_reg;

  logic              wr_en;
  logic              commit;
  logic              accept;
  logic              last_pix;
  logic [LINE_W-1:0] rd_addr;
  logic              unused_hsync;

  // Line end is taken from VDE alone; the upstream HSync carries no extra information.
  assign unused_hsync = vid_pHSync_i;

  assign wr_en    = vid_pVDE_i && !full_reg[wbank_reg] && !waddr_reg[LINE_W] && !sw_reset;
  assign commit   = vde_d_reg && !vid_pVDE_i && (waddr_reg != '0);
  assign accept   = (rstate_reg == R_STREAM) && vid_pReady_i;
  assign last_pix = accept && (((LINE_W+1)'(raddr_reg) + (LINE_W+1)'(1)) == len_reg[rbank_reg]);

  // Prefetch the next address so the registered read data is valid every VDE cycle;
  // outside the stream the address parks at 0 ready for the next burst.
  assign rd_addr = (rstate_reg == R_STREAM) ? raddr_reg + LINE_W'(accept) : '0;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wbank_reg, waddr_reg[LINE_W-1:0]}] <= vid_pData_i;
    end
    rd_data_reg <= mem[{rbank_reg, rd_addr}];
  end

  assign vid_pData_o = vid_pVDE_o ? rd_data_reg : 8'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wbank_reg    <= 1'b0;
      rbank_reg    <= 1'b0;
      vde_d_reg    <= 1'b0;
      waddr_reg    <= '0;
      raddr_reg    <= '0;
      len_reg      <= '0;
      full_reg     <= 2'b00;
      rstate_reg   <= R_IDLE;
      hcnt_reg     <= '0;
      vid_pHSync_o <= 1'b0;
      vid_pVSync_o <= 1'b0;
      vid_pVDE_o   <= 1'b0;
      overflow_o   <= 1'b0;
      line_len_o   <= '0;
    end else if (sw_reset) begin
      wbank_reg    <= 1'b0;
      rbank_reg    <= 1'b0;
      vde_d_reg    <= 1'b0;
      waddr_reg    <= '0;
      raddr_reg    <= '0;
      len_reg      <= '0;
      full_reg     <= 2'b00;
      rstate_reg   <= R_IDLE;
      hcnt_reg     <= '0;
      vid_pHSync_o <= 1'b0;
      vid_pVSync_o <= 1'b0;
      vid_pVDE_o   <= 1'b0;
      overflow_o   <= 1'b0;
      line_len_o   <= '0;
    end else begin
      vid_pVSync_o <= vid_pVSync_i;
      vde_d_reg    <= vid_pVDE_i;

      if (wr_en) begin
        waddr_reg <= waddr_reg + (LINE_W+1)'(1);
      end else if (vid_pVDE_i) begin
        overflow_o <= 1'b1;
      end

      // Commit and release always target different banks, so both may land together.
      if (commit) begin
        len_reg[wbank_reg]  <= waddr_reg;
        line_len_o          <= waddr_reg;
        full_reg[wbank_reg] <= 1'b1;
        wbank_reg           <= ~wbank_reg;
        waddr_reg           <= '0;
      end
      if (last_pix) begin
        full_reg[rbank_reg] <= 1'b0;
      end

      case (rstate_reg)
        R_IDLE: begin
          if (full_reg[rbank_reg]) begin
            rstate_reg   <= R_HSYNC;
            vid_pHSync_o <= 1'b1;
            hcnt_reg     <= '0;
          end
        end
        R_HSYNC: begin
          if (hcnt_reg == HC_W'(HSYNC_LEN - 1)) begin
            rstate_reg   <= R_GAP;
            vid_pHSync_o <= 1'b0;
          end else begin
            hcnt_reg <= hcnt_reg + HC_W'(1);
          end
        end
        R_GAP: begin
          rstate_reg <= R_STREAM;
          vid_pVDE_o <= 1'b1;
          raddr_reg  <= '0;
        end
        R_STREAM: begin
          if (accept) begin
            raddr_reg <= rd_addr;
            if (last_pix) begin
              rbank_reg  <= ~rbank_reg;
              rstate_reg <= R_IDLE;
              vid_pVDE_o <= 1'b0;
            end
          end
        end
        default: rstate_reg <= R_IDLE;
      endcase
    end
  end
endmodule

// File: doc/hor_line_feeder.md
# hor_line_feeder

Ping-pong line buffer that sits directly upstream of the horizontal averaging filter. It absorbs a free-running 8-bit video stream that has no back-pressure. It replays each completed line to the filter as one HSync pulse followed by a pixel burst that honours the filter's `ready` stall. This lets the filter emit several sums per input pixel (dx < 1) without losing data.

## Interface
Parameters:
- `LINE_W`, 11: log2 of bank depth; each of the 2 banks holds 2^LINE_W pixels.
- `HSYNC_LEN`, 4: output HSync pulse width in cycles (≥1).

Ports:
- `clk`  in  1  single clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `vid_pData_i`  in  8  upstream pixel.
- `vid_pHSync_i`  in  1  upstream HSync (unused except documentation; line end is taken from VDE).
- `vid_pVSync_i`  in  1  upstream VSync.
- `vid_pVDE_i`  in  1  upstream active video; pixel written every cycle it is high.
- `vid_pData_o`  out  8  pixel to filter.
- `vid_pHSync_o`  out  1  regenerated HSync.
- `vid_pVSync_o`  out  1  VSync, registered.
- `vid_pVDE_o`  out  1  pixel valid to filter.
- `vid_pReady_i`  in  1  filter accepts current pixel this cycle.
- `sw_reset`  in  1  synchronous soft clear.
- `overflow_o`  out  1  sticky; a pixel was dropped.
- `line_len_o`  out  LINE_W+1  length of the last line committed by the write side.

## Operation
- Write side:
  - State: `wbank`, `waddr`, `len[2]`, `full[2]`.
  - Each cycle with VDE_i=1, `full[wbank]`=0 and `waddr` < 2^LINE_W: store the pixel at `[wbank][waddr]`, then `waddr`++.
  - Otherwise a VDE_i=1 pixel is dropped and `overflow_o` is set.
- Line commit: on a VDE_i 1→0 transition with `waddr` ≠ 0:
  - Set `len[wbank]`=`waddr` and `line_len_o`=`waddr`.
  - Set `full[wbank]`=1, toggle `wbank`, clear `waddr`.
  - If the line was dropped entirely (`waddr`=0), there is no commit.
- Read FSM, with `rbank` and `raddr`:
  - R_IDLE: all outputs low except VSync. Go to R_HSYNC when `full[rbank]`.
  - R_HSYNC: `vid_pHSync_o`=1 for HSYNC_LEN cycles, then go to R_GAP.
  - R_GAP: 1 cycle with HSync_o=0 and VDE_o=0, giving the filter time to detect the HSync falling edge. Then go to R_STREAM with `raddr`=0.
  - R_STREAM: VDE_o=1 and Data_o = `mem[rbank][raddr]`. On Ready_i=1, `raddr`++. When Ready_i=1 and `raddr`=`len[rbank]`-1:
    - Clear `full[rbank]` and toggle `rbank`.
    - Go to R_IDLE; VDE_o is low the next cycle.
- Memory is synchronous-read. The implementation prefetches the read address as `raddr + accept`, so Data_o is valid in every VDE_o cycle.
- Write and read always address different banks. A commit and a release in the same cycle are independent and both take effect.
- `vid_pVSync_o` = `vid_pVSync_i` delayed 1 cycle.
- `sw_reset`=1 has the same effect as reset on the next edge, including clearing `overflow_o`. It takes priority over all writes and reads in that cycle.
- Reset (asynchronous) values:
  - All outputs are 0.
  - `full` = {0,0}, `wbank`=`rbank`=0, `waddr`=`raddr`=0, FSM is R_IDLE.
  - A reset mid-line discards both banks.

## Timing
- Cycle 0 is the first cycle VDE_i is sampled low after a line.
  - `full` is set at the cycle 1 edge.
  - R_HSYNC is entered and HSync_o rises at cycle 2.
  - HSync_o is high for cycles 2..1+HSYNC_LEN.
  - R_GAP occupies cycle 2+HSYNC_LEN.
  - The first VDE_o cycle is 3+HSYNC_LEN (7 with the defaults).
- A pixel is held stable on Data_o/VDE_o until the cycle Ready_i=1. The next pixel appears the following cycle.
- With Ready_i tied high, a line of N pixels streams in exactly N cycles.
- With one line buffered, the next line can start writing in cycle 1 into the other bank. Sustained throughput needs per-line stream time ≤ input line period.

## Test plan
- Single line 1..8, Ready_i=1 → HSync_o high cycles 2–5, VDE_o high cycles 7–14, Data_o 1..8, `line_len_o`=8, `overflow_o`=0.
- Same line with Ready_i pattern 1,0,0,1,0,1,1,1,1,1,1 → each value held during Ready_i=0 cycles; accepted sequence exactly 1..8, with no duplicate or skip.
- Three 8-pixel lines back-to-back with Ready_i=0 → lines 1 and 2 buffered, line 3 dropped, `overflow_o`=1. Releasing Ready_i streams line 1 then line 2. `overflow_o` stays 1 until `sw_reset`.
- LINE_W=4, one line of 20 pixels (values 0..19) → 0..15 streamed, `line_len_o`=16, `overflow_o`=1.
- Assert `resetn`=0 in the middle of a stream at pixel 3 → all outputs 0 immediately. After release, a new line of 5 pixels streams from pixel 0, and the old data never appears.
- Toggle `vid_pVSync_i` at arbitrary cycles → `vid_pVSync_o` follows exactly 1 cycle later, independent of FSM state.
